mdu_seq: RTL

- Iterative multiply/divide sequencer for the pipelined MIPS core.
- Owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU as a 32-iteration shift-add or restoring-divide loop.
- Accepts operations from the Execute stage.
- Produces a stall request that the hazard unit ORs into StallF/StallD, so a decode-stage HI/LO consumer waits until results are committed.

---
 rtl/mdu_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// MULT/MULTU use a 1-bit-per-cycle shift-add loop (LSB first); DIV/DIVU use
// a restoring divider producing 1 quotient bit per cycle (MSB first). Signed
// operations run on magnitudes and are sign-corrected in the single FIX cycle.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             HiLoUseD,
  output logic             Busy,
  output logic             StallMD,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       op_q, op_d;          // [1]: divide, [0]: unsigned
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             divzero_q, divzero_d;
  logic [WIDTH-1:0] srca_q, srca_d;      // original dividend for divide-by-zero
  logic [WIDTH-1:0] m_q, m_d;            // |multiplicand| or |divisor|
  logic [WIDTH-1:0] q_q, q_d;            // multiplier -> low product / dividend -> quotient
  logic [WIDTH-1:0] acc_q, acc_d;        // high product / partial remainder
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             start_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_trial;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand conditioning and single-iteration datapath, shared by all states.
  always_comb begin
    start_signed = ~OpE[0];
    abs_a = (start_signed && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    abs_b = (start_signed && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the {acc, q} pair right by one.
    mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});

    // Restoring divide: bring in the next dividend bit and trial-subtract.
    div_shift = {acc_q, q_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, m_q};

    prod     = {acc_q, q_q};
    prod_fix = (!op_q[0] && neg_res_q) ? -prod : prod;
    quo_fix  = (!op_q[0] && neg_res_q) ? -q_q : q_q;
    rem_fix  = (!op_q[0] && neg_rem_q) ? -acc_q : acc_q;
  end

  // Next-state, datapath update and output decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divzero_d = divzero_q;
    srca_d    = srca_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    Busy      = (state_q != IDLE);
    Done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A start while busy cannot reach here; the hazard stall prevents it.
        if (StartE) begin
          op_d      = OpE;
          m_d       = abs_b;
          q_d       = abs_a;
          acc_d     = '0;
          neg_res_d = start_signed & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
          neg_rem_d = start_signed & SrcAE[WIDTH-1];
          divzero_d = (SrcBE == '0);
          srca_d    = SrcAE;
          count_d   = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (op_q[1]) begin
          if (!div_trial[WIDTH]) begin
            acc_d = div_trial[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[WIDTH:1];
          q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == CW'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        Done = 1'b1;
        if (!op_q[1]) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (divzero_q) begin
          hi_d = srca_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign StallMD = HiLoUseD & (Busy | StartE);
  assign HI      = hi_q;
  assign LO      = lo_q;

  // State, counter and datapath registers; reset abandons any operation.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divzero_q <= 1'b0;
      srca_q    <= '0;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divzero_q <= divzero_d;
      srca_q    <= srca_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule
